// File: rtl/sssp_scatter_lanes_if.sv
// Beat-input and per-lane update-output bundle of the multi-lane SSSP scatter block.
// The master side drives beats and pops updates; the slave side is the scatter block itself.
interface sssp_scatter_lanes_if #(
  parameter int LANES = 4
);
  logic [1:0]          control;
  logic [15:0]         current_level;
  logic [511:0]        word_in;
  logic [31:0]         w_addr;
  logic                word_in_valid;
  logic                last_in;
  logic                in_ready;
  logic [LANES*64-1:0] out_data;
  logic [LANES-1:0]    out_valid;
  logic [LANES-1:0]    out_ready;
  logic                done;

  modport master (
    output control, current_level, word_in, w_addr, word_in_valid, last_in, out_ready,
    input  in_ready, out_data, out_valid, done
  );

  modport slave (
    input  control, current_level, word_in, w_addr, word_in_valid, last_in, out_ready,
    output in_ready, out_data, out_valid, done
  );
endinterface

// File: rtl/sssp_scatter_lanes.sv
// Multi-lane SSSP scatter: per-partition vertex store loaded from cachelines, a 4-stage
// edge pipeline producing saturating {dst, weight+edge_weight} updates into per-lane FIFOs.
module sssp_scatter_lanes #(
  parameter int LANES      = 4,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  sssp_scatter_lanes_if.slave bus
);

  localparam int PW    = 32 - ADDR_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    MODE_NONE    = 2'd0,
    MODE_LOAD    = 2'd1,
    MODE_SCATTER = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef struct packed {
    logic [31:0] weight;
    logic [15:0] level;
  } vertex_t;

  // Per-beat side information that travels with the beat through every stage.
  typedef struct packed {
    logic        valid;
    mode_e       mode;
    logic        last;
    logic [15:0] level;
  } ctl_t;

  typedef struct packed {
    logic [31:0] dst;
    logic [31:0] ew;
    logic        ok;
  } lane_t;

  logic  ready;
  logic  accept;
  mode_e in_mode;

  assign in_mode = mode_e'(bus.control);
  assign accept  = bus.word_in_valid & ready;

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  ctl_t s1_ctl_q, s2_ctl_q, s3_ctl_q, s4_ctl_q;
  ctl_t s1_ctl_d;

  lane_t             s1_lane_q [LANES];
  lane_t             s1_lane_d [LANES];
  logic [ADDR_W-1:0] s1_addr_q [LANES];
  logic [ADDR_W-1:0] s1_addr_d [LANES];
  lane_t             s2_lane_q [LANES];
  lane_t             s3_lane_q [LANES];
  vertex_t           rd_q      [LANES];
  vertex_t           s3_vtx_q  [LANES];

  logic [LANES-1:0] s4_push_q, s4_push_d;
  logic [63:0]      s4_data_q [LANES];
  logic [63:0]      s4_data_d [LANES];
  logic [32:0]      sum33     [LANES];

  logic [PW-1:0] prefix_q, prefix_d;
  logic          last_left_q, last_left_d;
  logic          done_q, done_d;

  vertex_t ram [LANES][DEPTH];

  // Input stage: the prefix check uses the prefix as of acceptance, so a load
  // accepted in an earlier cycle always governs this beat.
  always_comb begin
    s1_ctl_d       = '0;
    s1_ctl_d.valid = accept;
    s1_ctl_d.mode  = in_mode;
    s1_ctl_d.last  = bus.last_in;
    s1_ctl_d.level = bus.current_level;
    for (int l = 0; l < LANES; l++) begin
      s1_lane_d[l].dst = bus.word_in[l*128+32 +: 32];
      s1_lane_d[l].ew  = bus.word_in[l*128+64 +: 32];
      s1_lane_d[l].ok  = (bus.word_in[l*128 +: 32] != 32'hFFFF_FFFF) &&
                         (bus.word_in[l*128+ADDR_W +: PW] == prefix_q);
      s1_addr_d[l]     = bus.word_in[l*128 +: ADDR_W];
    end
  end

  // Filter and saturating add feeding the FIFO push register.
  always_comb begin
    s4_push_d = '0;
    for (int l = 0; l < LANES; l++) begin
      sum33[l]     = {1'b0, s3_vtx_q[l].weight} + {1'b0, s3_lane_q[l].ew};
      s4_push_d[l] = s3_ctl_q.valid && (s3_ctl_q.mode == MODE_SCATTER) && s3_lane_q[l].ok &&
                     (s3_vtx_q[l].level == s3_ctl_q.level) &&
                     (s3_vtx_q[l].weight != 32'hFFFF_FFFF);
      s4_data_d[l] = {s3_lane_q[l].dst, sum33[l][32] ? 32'hFFFF_FFFF : sum33[l][31:0]};
    end
  end

  assign prefix_d = (accept && in_mode == MODE_LOAD) ? bus.w_addr[31:ADDR_W] : prefix_q;

  // ---------------------------------------------------------------------------
  // Output FIFOs
  // ---------------------------------------------------------------------------
  logic [63:0]      fifo_mem [LANES][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [LANES];
  logic [PTR_W-1:0] wr_ptr_d [LANES];
  logic [PTR_W-1:0] rd_ptr_q [LANES];
  logic [PTR_W-1:0] rd_ptr_d [LANES];
  logic [CNT_W-1:0] cnt_q    [LANES];
  logic [CNT_W-1:0] cnt_d    [LANES];
  logic [LANES-1:0] pop;
  logic             all_empty;

  always_comb begin
    pop       = '0;
    ready     = 1'b1;
    all_empty = 1'b1;
    for (int l = 0; l < LANES; l++) begin
      pop[l]      = (cnt_q[l] != '0) && bus.out_ready[l];
      wr_ptr_d[l] = wr_ptr_q[l] + PTR_W'(s4_push_q[l]);
      rd_ptr_d[l] = rd_ptr_q[l] + PTR_W'(pop[l]);
      cnt_d[l]    = cnt_q[l] + CNT_W'(s4_push_q[l]) - CNT_W'(pop[l]);
      // Headroom for the four in-flight beats plus the one being accepted.
      if (cnt_q[l] > CNT_W'(FIFO_DEPTH - 5)) ready = 1'b0;
      if (cnt_q[l] != '0) all_empty = 1'b0;
    end
  end

  always_comb begin
    if (accept) begin
      last_left_d = 1'b0;
      done_d      = 1'b0;
    end else begin
      last_left_d = last_left_q | (s4_ctl_q.valid & s4_ctl_q.last);
      done_d      = done_q | (last_left_q & all_empty);
    end
  end

  // ---------------------------------------------------------------------------
  // Control state: valids, prefix, FIFO bookkeeping, done
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_ctl_q    <= '0;
      s2_ctl_q    <= '0;
      s3_ctl_q    <= '0;
      s4_ctl_q    <= '0;
      s4_push_q   <= '0;
      prefix_q    <= '0;
      last_left_q <= 1'b0;
      done_q      <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        cnt_q[l]    <= '0;
      end
    end else begin
      s1_ctl_q    <= s1_ctl_d;
      s2_ctl_q    <= s1_ctl_q;
      s3_ctl_q    <= s2_ctl_q;
      s4_ctl_q    <= s3_ctl_q;
      s4_push_q   <= s4_push_d;
      prefix_q    <= prefix_d;
      last_left_q <= last_left_d;
      done_q      <= done_d;
      for (int l = 0; l < LANES; l++) begin
        wr_ptr_q[l] <= wr_ptr_d[l];
        rd_ptr_q[l] <= rd_ptr_d[l];
        cnt_q[l]    <= cnt_d[l];
      end
    end
  end

  // NOTE: storage and datapath registers carry no reset; every consumer is
  // qualified by a reset valid or count, and resetting RAM would block inference.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (accept && in_mode == MODE_LOAD) begin
        for (int v = 0; v < 8; v++) begin
          ram[l][bus.w_addr[ADDR_W-1:0] + ADDR_W'(v)] <=
            {bus.word_in[v*64 +: 32], bus.word_in[v*64+32 +: 16]};
        end
      end
      s1_lane_q[l] <= s1_lane_d[l];
      s1_addr_q[l] <= s1_addr_d[l];
      rd_q[l]      <= ram[l][s1_addr_q[l]];
      s2_lane_q[l] <= s1_lane_q[l];
      s3_lane_q[l] <= s2_lane_q[l];
      s3_vtx_q[l]  <= rd_q[l];
      s4_data_q[l] <= s4_data_d[l];
      if (s4_push_q[l]) fifo_mem[l][wr_ptr_q[l]] <= s4_data_q[l];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.out_data  = '0;
    bus.out_valid = '0;
    for (int l = 0; l < LANES; l++) begin
      bus.out_valid[l] = (cnt_q[l] != '0);
      if (cnt_q[l] != '0) bus.out_data[l*64 +: 64] = fifo_mem[l][rd_ptr_q[l]];
    end
  end

  assign bus.in_ready = ready;
  assign bus.done     = done_q;

  // Reserved fields of vertices and edges, and lanes beyond LANES, are not consumed.
  logic unused_word;
  assign unused_word = ^bus.word_in;

endmodule

// File: doc/sssp_scatter_lanes.md
# sssp_scatter_lanes

Multi-lane, back-pressured successor to the single-lane SSSP scatter pipeline in the edge-centric accelerator. It is a per-partition vertex store, loaded from 512-bit cachelines. In scatter mode it processes up to LANES edges per beat. For each edge whose source matches the current level and the loaded partition, it emits an update `{dst, src_weight + edge_weight}` into a per-lane output FIFO. It adds three things the single-lane pipeline lacks:
- upstream flow control;
- padding and unreached-vertex filtering with saturating arithmetic;
- a drain/done indication.

## Interface
Parameters:
- LANES, 4: edge lanes per beat, 1..4.
- ADDR_W, 8: log2 of the vertex partition size; must be ≥3.
- FIFO_DEPTH, 16: entries per lane output FIFO; power of two, ≥8.

Ports:
- clk  in  1  Rising-edge clock.
- rst  in  1  Reset. One clock; reset is asynchronous and active-high.
- control  in  2  Mode, sampled with each accepted beat: 1 = load vertices, 2 = scatter, other values = ignore beat.
- current_level  in  16  BFS level to match; sampled with each accepted beat.
- word_in  in  512  Cacheline.
- w_addr  in  32  Vertex index of vertex 0 of a load beat; 8-aligned.
- word_in_valid  in  1  Beat valid.
- last_in  in  1  Marks the final beat of a pass; qualified by the accept condition.
- in_ready  out  1  Beat accepted when word_in_valid & in_ready.
- out_data  out  LANES*64  Lane l occupies [l*64+:64], as {dst[31:0], sum[31:0]}.
- out_valid  out  LANES  Per-lane FIFO not empty.
- out_ready  in  LANES  Per-lane pop.
- done  out  1  Sticky; the last beat has retired and all FIFOs are empty.

## Operation
- Load beat (control=1):
  - The beat carries 8 vertices. Vertex v is word_in[v*64+:64], laid out as weight [31:0], level [47:32], reserved [63:48].
  - Vertex v is written to entry (w_addr[ADDR_W-1:0] + v) in every lane's RAM copy.
  - prefix ← w_addr[31:ADDR_W].
- Scatter beat (control=2):
  - Lane l takes edge word_in[l*128+:128], laid out as src [31:0], dst [63:32], weight [95:64], reserved [127:96].
  - The lane reads its RAM at src[ADDR_W-1:0].
  - An update is pushed only if all of the following hold:
    - src != 32'hFFFFFFFF (padding);
    - src[31:ADDR_W] == prefix;
    - vertex.level == current_level captured with the beat;
    - vertex.weight != 32'hFFFFFFFF (unreached).
  - sum = vertex.weight + edge.weight, 33-bit, clamped to 32'hFFFFFFFF on overflow.
- Mode, level and last_in travel down the pipeline with their beat. Mode changes mid-stream are therefore safe.
- RAM is read-old-on-collision. A scatter beat accepted in any cycle after a load beat sees that load's data.
- Flow control: in_ready = 1 iff, for every lane, the FIFO count ≤ FIFO_DEPTH−5. This covers 4 in-flight beats plus the current one, so the FIFOs never overflow. Pushes are never dropped for lack of space.
- FIFOs:
  - Show-ahead: out_data is the head entry whenever out_valid is set.
  - A pop happens on out_valid & out_ready.
  - A simultaneous push and pop on the same lane leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- done:
  - Set the cycle after the accepted last_in beat has left pipeline stage 4 and all FIFO counts are 0.
  - Cleared when the next beat is accepted.
- rst, including mid-operation:
  - Clears the pipeline valids, FIFO pointers and counts, prefix and done.
  - RAM contents are not cleared.
  - In-flight beats are discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, done=0.
- Pipeline, for a beat accepted at cycle T:
  - T+1: edge and address registered.
  - T+2 and T+3: RAM read.
  - T+4: filter and saturating add registered.
  - End of T+4: FIFO push.
- With an empty FIFO and out_ready=1, out_valid rises at T+5; latency is 5 cycles.
- Throughput: 1 beat/cycle while in_ready=1, i.e. LANES updates/cycle.
- in_ready is combinational from the registered FIFO counts only; there is no path from word_in_valid or out_ready to in_ready.
- For a load accepted at T, the RAM write commits at the end of T.

## Test plan
- Load prefix 0x0000_0100: load beat w_addr=0x100, vertex 3 = {level 2, weight 10}. Then scatter lane 0 with edge {src 0x103, dst 0x55, w 7} at level 2 -> lane 0 out {0x55, 17} at T+5; other lanes silent.
- Filtering: same setup, with lane 1 src 0x203 (prefix miss), lane 2 src 0xFFFFFFFF, lane 3 src 0x103 at level 3 -> no output on lanes 1–3.
- Saturation: vertex weight 0xFFFF_FFF0, edge weight 0x20 -> sum 0xFFFF_FFFF. Vertex weight 0xFFFF_FFFF -> no push.
- Backpressure (FIFO_DEPTH=16): out_ready=0, continuous matching beats -> in_ready falls once a count reaches 12; counts stop at ≤16, never 17. Release out_ready -> all 16 entries pop in push order per lane.
- Drain: last_in on the final matching beat -> done stays 0 until all FIFOs pop empty, then rises the next cycle. A new beat clears it.
- Async reset mid-stream: assert rst between clock edges with 3 beats in flight -> outputs go to reset values immediately; no stale outputs after release. A reload plus scatter then produces correct results.
